// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if: start/busy/done handshake and data bus for bin2bcd_seq.
//   start  : request a conversion (master -> slave)
//   bin    : unsigned binary value, WIDTH bits (master -> slave)
//   bcd    : packed BCD result, 4*DIGITS bits, ones in [3:0] (slave -> master)
//   busy   : conversion in progress (slave -> master)
//   done   : one-cycle pulse when bcd has just been updated (slave -> master)
`timescale 1ns/1ps
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;

  modport master (output start, bin, input bcd, busy, done);
  modport slave  (input start, bin, output bcd, busy, done);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble), one input
// bit per clock. A conversion accepted in IDLE takes WIDTH CONV cycles; the
// result is registered on bcd with a one-cycle done pulse.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : bin2bcd_seq_if.slave (start, bin, bcd, busy, done)
// Optional feature: define LEADING_ZERO_BLANK_EN to replace zero digits above
// the most-significant nonzero digit with 4'hF (ones digit never blanked).
`timescale 1ns/1ps
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  bin2bcd_seq_if.slave        bus
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_nxt;
  logic [SW-1:0]    result;
  logic [CW-1:0]    count;
  logic [SW-1:0]    bcd_q;
  logic             busy_q;
  logic             done_q;

  // Add 3 to every digit >= 5, all digits in parallel, before the shift.
  always_comb begin
    adj = scratch;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    {scratch_nxt, sr_nxt} = {adj, sr} << 1;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic lead;

  // Walk from the top digit down to the tens digit; blank while still in
  // the leading run of zeros.
  always_comb begin
    result = scratch_nxt;
    lead   = 1'b1;
    for (int unsigned j = 1; j < DIGITS; j++) begin
      if (lead && (scratch_nxt[4*(DIGITS-j) +: 4] == 4'd0))
        result[4*(DIGITS-j) +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  end
`else
  always_comb begin
    result = scratch_nxt;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      scratch <= '0;
      count   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          sr      <= bus.bin;
          scratch <= '0;
          count   <= '0;
          busy_q  <= 1'b1;
          state   <= CONV;
        end
      end else begin
        sr      <= sr_nxt;
        scratch <= scratch_nxt;
        count   <= count + CW'(1);
        if (count == LAST) begin
          bcd_q  <= result;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      end
    end
  end

  assign bus.bcd  = bcd_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.WIDTH(8), .DIGITS(3)) bus ();
  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  bin2bcd_seq_if #(.WIDTH(10), .DIGITS(4)) bus10 ();
  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Reference model state (transaction level: accept, then complete WIDTH edges later)
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [11:0] m_bcd  = '0;
  logic [7:0]  m_val  = '0;
  int          m_left = 0;

  // Expected packed BCD by division; a digit above the ones place is blank
  // when the value is smaller than that digit's place weight.
  function automatic logic [11:0] model_bcd(int unsigned v);
    logic [11:0] r;
    int unsigned p;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < p) r[4*i +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_bcd  <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_bcd  <= model_bcd(m_val);
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_left <= 8;
        m_val  <= bus.bin;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("mon_busy", 16'(bus.busy), 16'(m_busy));
        check("mon_done", 16'(bus.done), 16'(m_done));
        check("mon_bcd",  16'(bus.bcd),  16'(m_bcd));
      end
    end
  endtask

  // Waits (bounded) for done; counts busy cycles seen before it.
  task automatic wait_done(output int busy_n);
    bit ok;
    ok = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
    end
    if (!ok) check("done_timeout", 16'd0, 16'd1);
  endtask

  task automatic conv(input logic [7:0] v, output int busy_n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = v;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.done) busy_n = 0;
    else begin
      wait_done(busy_n);
      busy_n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bn, t1, t2, nd;
    logic [11:0] e0, e7, e40, e99;
`ifdef LEADING_ZERO_BLANK_EN
    e0 = 12'hFF0; e7 = 12'hFF7; e40 = 12'hF40; e99 = 12'hF99;
`else
    e0 = 12'h000; e7 = 12'h007; e40 = 12'h040; e99 = 12'h099;
`endif
    bus.start = 1'b0; bus.bin = '0;
    bus10.start = 1'b0; bus10.bin = '0;
    fork monitor(); join_none

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_bcd",  16'(bus.bcd),  16'h0);
    check("rst_busy", 16'(bus.busy), 16'h0);
    check("rst_done", 16'(bus.done), 16'h0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // 255: busy for 8 cycles, single-cycle done
    conv(8'd255, bn);
    check("b255_busy_cycles", 16'(bn), 16'd8);
    check("b255_bcd", 16'(bus.bcd), 16'h255);
    @(negedge clk);
    check("b255_done_1cyc", 16'(bus.done), 16'd0);

    conv(8'd0, bn);  check("b0_bcd",  16'(bus.bcd), 16'(e0));
    conv(8'd7, bn);  check("b7_bcd",  16'(bus.bcd), 16'(e7));
    conv(8'd40, bn); check("b40_bcd", 16'(bus.bcd), 16'(e40));

    // Back-to-back with start held high; bin changes while busy
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 8'd100;
    @(negedge clk);
    check("b2b_busy", 16'(bus.busy), 16'd1);
    bus.bin = 8'd99;
    wait_done(bn);
    t1 = cyc;
    check("b2b_first_bcd", 16'(bus.bcd), 16'h100);
    wait_done(bn);
    t2 = cyc;
    bus.start = 1'b0;
    check("b2b_second_bcd", 16'(bus.bcd), 16'(e99));
    check("b2b_period", 16'(t2 - t1), 16'd9);

    // Starts during a conversion are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 8'd123;
    @(negedge clk);
    nd = 0;
    for (int k = 1; k <= 15; k++) begin
      bus.start = (k == 3 || k == 5);
      @(negedge clk);
      if (bus.done) nd++;
    end
    bus.start = 1'b0;
    check("ignored_start_dones", 16'(nd), 16'd1);
    check("ignored_start_bcd", 16'(bus.bcd), 16'(model_bcd(123)));

    // Reset in the 4th CONV cycle
    @(negedge clk);
    bus.start = 1'b1; bus.bin = 8'd50;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("midrst_busy", 16'(bus.busy), 16'd0);
    check("midrst_done", 16'(bus.done), 16'd0);
    check("midrst_bcd",  16'(bus.bcd),  16'd0);
    conv(8'd128, bn);
    check("b128_bcd", 16'(bus.bcd), 16'h128);

    // Exhaustive sweep against the division model
    for (int v = 0; v < 256; v++) begin
      conv(8'(v), bn);
      check("sweep_bcd", 16'(bus.bcd), 16'(model_bcd(v)));
    end

    // Random start/bin/reset traffic, checked by the monitor every cycle
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) == 0);
      bus.bin   = 8'($urandom);
      rst       = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    repeat (12) @(negedge clk);

    // WIDTH=10, DIGITS=4 spot check
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus10.start = 1'b1; bus10.bin = 10'd1023;
    @(negedge clk);
    bus10.start = 1'b0;
    nd = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus10.done) begin
        nd = 1;
        break;
      end
    end
    check("w10_done_seen", 16'(nd), 16'd1);
    check("w10_bcd", bus10.bcd, 16'h1023);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
